buzzer_arbiter: RTL

- Shares one alarm-sounding resource (the buzzer outputs) between N sensor requesters.
- Debounces each sensor and latches a pending alarm per requester. Grants the buzzer to one requester at a time, round-robin, for a fixed on-time, then enforces a silent gap.
- Sits between raw ui sensor pins and uo buzzer pins in the top-level alarm design.

---
 rtl/buzzer_pkg.sv | 29 ++
 rtl/sensor_debounce.sv | 41 ++++
 rtl/buzzer_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/buzzer_pkg.sv
// Shared types, default timing and width helpers for the buzzer arbiter.
package buzzer_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOUND = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Default configuration
    localparam int unsigned DEF_N_REQ      = 3;
    localparam int unsigned DEF_DEB_CYCLES = 4;
    localparam int unsigned DEF_ON_CYCLES  = 8;
    localparam int unsigned DEF_GAP_CYCLES = 2;

    // Width of a requester index (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of the on/gap down-counter
    function automatic int unsigned cnt_width(input int unsigned on_cyc, input int unsigned gap_cyc);
        int unsigned mx;
        mx = (on_cyc > gap_cyc) ? on_cyc : gap_cyc;
        return $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Per-sensor debounce: saturating run-length counter with a registered
// stable flag and a combinational pulse on the cycle stable is about to rise.
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sensor_i,
    output logic stable_o,
    output logic rise_c
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

    logic [DW-1:0] r_cnt;
    logic          r_stable;
    logic          w_stable_nxt;

    // Stable is the registered view of a saturated counter
    assign w_stable_nxt = (r_cnt == DW'(DEB_CYCLES));

    // Count consecutive high samples, clear on any low sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (ena) begin
            if (!sensor_i) begin
                r_cnt <= '0;
            end else if (r_cnt != DW'(DEB_CYCLES)) begin
                r_cnt <= r_cnt + DW'(1);
            end
            r_stable <= w_stable_nxt;
        end
    end

    assign stable_o = r_stable;
    assign rise_c   = w_stable_nxt & ~r_stable;

endmodule

// File: rtl/buzzer_arbiter.sv
// Round-robin arbiter sharing one buzzer bank between debounced sensors.
// Optional: define BUZZER_ARBITER_MUTE_EN to add mute_i, which forces
// buzz_o low without disturbing arbitration.
module buzzer_arbiter
    import buzzer_pkg::*;
#(
    parameter int unsigned N_REQ      = DEF_N_REQ,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned ON_CYCLES  = DEF_ON_CYCLES,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [N_REQ-1:0]              sensor_i,
`ifdef BUZZER_ARBITER_MUTE_EN
    input  logic                          mute_i,
`endif
    output logic [N_REQ-1:0]              buzz_o,
    output logic                          busy_o,
    output logic [idx_width(N_REQ)-1:0]   grant_id_o,
    output logic                          done_o
);

    localparam int unsigned GW = idx_width(N_REQ);
    localparam int unsigned CW = cnt_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [GW-1:0]    r_ptr, w_ptr_nxt;
    logic [GW-1:0]    r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] r_buzz, w_buzz_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_rise;
    logic [N_REQ-1:0] w_stable_unused;
    logic             w_any;
    logic [GW-1:0]    w_sel;

    // One debouncer per requester
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_deb
        sensor_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .sensor_i (sensor_i[g]),
            .stable_o (w_stable_unused[g]),
            .rise_c   (w_rise[g])
        );
    end

    // Round-robin pick: first pending bit above the pointer, wrapping
    always_comb begin
        int idx;
        w_any = |r_pending;
        w_sel = r_ptr;
        idx   = 0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            idx = int'((32'(r_ptr) + 32'(k)) % N_REQ);
            if (r_pending[GW'(idx)]) begin
                w_sel = GW'(idx);
            end
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_clr       = '0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SOUND;
                    w_grant_nxt = w_sel;
                    w_ptr_nxt   = w_sel;
                    w_cnt_nxt   = CW'(ON_CYCLES - 1);
                end
            end
            SOUND: begin
                if (r_cnt == '0) begin
                    w_state_nxt = GAP;
                    w_clr       = ONE_HOT0 << r_grant;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = CW'(GAP_CYCLES - 1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    if (w_any) begin
                        w_state_nxt = SOUND;
                        w_grant_nxt = w_sel;
                        w_ptr_nxt   = w_sel;
                        w_cnt_nxt   = CW'(ON_CYCLES - 1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_buzz_nxt = (w_state_nxt == SOUND) ? (ONE_HOT0 << w_grant_nxt) : '0;
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // FSM, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= GW'(N_REQ - 1);
            r_grant <= '0;
            r_buzz  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_buzz  <= w_buzz_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Pending alarms: a new stable rise beats a same-cycle completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else if (ena) begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

`ifdef BUZZER_ARBITER_MUTE_EN
    assign buzz_o = mute_i ? '0 : r_buzz;
`else
    assign buzz_o = r_buzz;
`endif
    assign busy_o     = r_busy;
    assign grant_id_o = r_grant;
    assign done_o     = r_done;

endmodule
